// File: rtl/debug_pkg.sv
// rtl/debug_pkg.sv - shared types and sizing helpers for the debug dump sequencer
package debug_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LATCH,
        SEND,
        ADVANCE,
        CHKSUM,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        SRC_PC,
        SRC_REG,
        SRC_MEM
    } src_e;

    localparam int DEF_DATA_SZ    = 32;
    localparam int DEF_BYTE_W     = 8;
    localparam int BYTES_PER_WORD = DEF_DATA_SZ / DEF_BYTE_W;

    function automatic int bytes_per_word(input int data_sz, input int byte_w);
        return data_sz / byte_w;
    endfunction

endpackage

// File: rtl/debug_dump_sequencer_if.sv
// rtl/debug_dump_sequencer_if.sv - debug read bus and UART TX FIFO handshake
interface debug_dump_sequencer_if #(
    parameter int DATA_SZ = 32,
    parameter int ADDR_W  = 5,
    parameter int BYTE_W  = 8
);
    logic [DATA_SZ-1:0] i_pc;
    logic [DATA_SZ-1:0] i_register_data;
    logic [DATA_SZ-1:0] i_memory_data;
    logic               i_tx_full;
    logic [ADDR_W-1:0]  o_addr;
    logic [BYTE_W-1:0]  o_w_data;
    logic               o_wr_uart;

    modport master (
        input  i_pc, i_register_data, i_memory_data, i_tx_full,
        output o_addr, o_w_data, o_wr_uart
    );

    modport slave (
        output i_pc, i_register_data, i_memory_data, i_tx_full,
        input  o_addr, o_w_data, o_wr_uart
    );
endinterface

// File: rtl/debug_dump_sequencer_word_serializer.sv
// rtl/debug_dump_sequencer_word_serializer.sv - shifts a loaded word out LSB byte first under the tx_full handshake
module word_serializer #(
    parameter int DATA_SZ = 32,
    parameter int BYTE_W  = 8
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [DATA_SZ-1:0] word_i,
    input  logic               en_i,
    input  logic               tx_full_i,
    output logic [BYTE_W-1:0]  byte_o,
    output logic               wr_o,
    output logic               last_byte_o
);
    localparam int BPW   = DATA_SZ / BYTE_W;
    localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

    logic [DATA_SZ-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;

    // Strobe is gated combinationally by tx_full so no write ever lands on a full FIFO.
    assign wr_o        = en_i && !tx_full_i;
    assign byte_o      = shreg_q[BYTE_W-1:0];
    assign last_byte_o = wr_o && (idx_q == IDX_W'(BPW - 1));

    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (load_i) begin
            shreg_d = word_i;
            idx_d   = '0;
        end else if (wr_o) begin
            shreg_d = shreg_q >> BYTE_W;
            idx_d   = idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: rtl/debug_dump_sequencer.sv
// rtl/debug_dump_sequencer.sv - dumps PC, register file and data memory to the UART TX FIFO
// Optional trailing XOR checksum byte: DEBUG_DUMP_CHECKSUM_EN
module debug_dump_sequencer
    import debug_pkg::*;
#(
    parameter int DATA_SZ = 32,
    parameter int ADDR_W  = 5,
    parameter int N_REGS  = 32,
    parameter int N_MEM   = 32,
    parameter int BYTE_W  = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    debug_dump_sequencer_if.master bus,
    output logic                   o_busy,
    output logic                   o_done
);
    localparam int BPW = bytes_per_word(DATA_SZ, BYTE_W);
    localparam logic [ADDR_W-1:0] REG_LAST = ADDR_W'(N_REGS - 1);
    localparam logic [ADDR_W-1:0] MEM_LAST = ADDR_W'(N_MEM - 1);

    if (N_REGS > 2**ADDR_W || N_MEM > 2**ADDR_W || N_REGS < 1 || N_MEM < 1) begin : g_bad_depth
        $error("N_REGS/N_MEM must be in 1..2**ADDR_W");
    end
    if (DATA_SZ % BYTE_W != 0 || BPW < 1) begin : g_bad_width
        $error("DATA_SZ must be a non-zero multiple of BYTE_W");
    end

    state_e             state_q, state_d;
    src_e               src_q, src_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               load;
    logic [DATA_SZ-1:0] word_sel;
    logic [BYTE_W-1:0]  ser_byte;
    logic               ser_wr;
    logic               ser_last;
    logic               wr;
    logic [BYTE_W-1:0]  wdata;

    always_comb begin
        word_sel = bus.i_memory_data;
        if (src_q == SRC_PC)       word_sel = bus.i_pc;
        else if (src_q == SRC_REG) word_sel = bus.i_register_data;
    end

    word_serializer #(
        .DATA_SZ (DATA_SZ),
        .BYTE_W  (BYTE_W)
    ) u_ser (
        .clk_i       (i_clk),
        .rst_ni      (i_reset),
        .load_i      (load),
        .word_i      (word_sel),
        .en_i        (state_q == SEND),
        .tx_full_i   (bus.i_tx_full),
        .byte_o      (ser_byte),
        .wr_o        (ser_wr),
        .last_byte_o (ser_last)
    );

`ifdef DEBUG_DUMP_CHECKSUM_EN
    logic [BYTE_W-1:0] chk_q, chk_d;

    always_comb begin
        chk_d = chk_q;
        if (state_q == IDLE && i_start) chk_d = '0;
        else if (ser_wr)                chk_d = chk_q ^ ser_byte;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) chk_q <= '0;
        else          chk_q <= chk_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        addr_d  = addr_q;
        load    = 1'b0;
        wr      = 1'b0;
        wdata   = '0;
        o_busy  = 1'b1;
        o_done  = 1'b0;
        case (state_q)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    state_d = SETUP;
                    src_d   = SRC_PC;
                    addr_d  = '0;
                end
            end
            SETUP: state_d = LATCH;
            LATCH: begin
                load    = 1'b1;
                state_d = SEND;
            end
            SEND: begin
                wr    = ser_wr;
                wdata = ser_wr ? ser_byte : '0;
                if (ser_last) state_d = ADVANCE;
            end
            ADVANCE: begin
                state_d = SETUP;
                case (src_q)
                    SRC_PC: begin
                        src_d  = SRC_REG;
                        addr_d = '0;
                    end
                    SRC_REG: begin
                        if (addr_q == REG_LAST) begin
                            src_d  = SRC_MEM;
                            addr_d = '0;
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end
                    default: begin
                        if (addr_q == MEM_LAST) begin
                            addr_d = '0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
                            state_d = CHKSUM;
`else
                            state_d = DONE;
`endif
                        end else begin
                            addr_d = addr_q + ADDR_W'(1);
                        end
                    end
                endcase
            end
`ifdef DEBUG_DUMP_CHECKSUM_EN
            CHKSUM: begin
                wr    = !bus.i_tx_full;
                wdata = bus.i_tx_full ? '0 : chk_q;
                if (!bus.i_tx_full) state_d = DONE;
            end
`endif
            DONE: begin
                o_busy  = 1'b0;
                o_done  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= IDLE;
            src_q   <= SRC_PC;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.o_addr    = addr_q;
    assign bus.o_wr_uart = wr;
    assign bus.o_w_data  = wdata;
endmodule

// File: tb/tb_debug_dump_sequencer.sv
// tb/tb_debug_dump_sequencer.sv - directed self-checking bench for debug_dump_sequencer
module tb_debug_dump_sequencer;
`ifdef DEBUG_DUMP_CHECKSUM_EN
    localparam int EXP_N = 261;
`else
    localparam int EXP_N = 260;
`endif

    logic clk = 1'b0;
    logic i_reset = 1'b0;
    logic i_start = 1'b0;
    logic tx_full = 1'b0;
    logic o_busy, o_done;

    always #5 clk = ~clk;

    debug_dump_sequencer_if #(.DATA_SZ(32), .ADDR_W(5), .BYTE_W(8)) bus ();

    assign bus.i_pc            = 32'h0000_0004;
    assign bus.i_register_data = 32'(bus.o_addr);
    assign bus.i_memory_data   = 32'hA5A5_0000 + 32'(bus.o_addr);
    assign bus.i_tx_full       = tx_full;

    debug_dump_sequencer #(
        .DATA_SZ (32), .ADDR_W (5), .N_REGS (32), .N_MEM (32), .BYTE_W (8)
    ) dut (
        .i_clk   (clk),
        .i_reset (i_reset),
        .i_start (i_start),
        .bus     (bus),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    typedef struct {
        int         idx;
        logic [7:0] exp;
    } vec_t;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] got[$];
    int         done_cnt, wr_full_err, addr_err, step_cnt, first_wr_step;
    bit         rand_full, start_hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int n);
        logic [31:0] w;
        logic [7:0]  x;
        if (n >= 260) begin
            x = 8'h00;
            for (int i = 0; i < 260; i++) x ^= exp_byte(i);
            return x;
        end
        if (n < 4)        w = 32'h0000_0004;
        else if (n < 132) w = 32'((n - 4) / 4);
        else              w = 32'hA5A5_0000 + 32'((n - 132) / 4);
        return w[8*(n%4) +: 8];
    endfunction

    task automatic sample();
        int n;
        int ea;
        if (bus.o_wr_uart) begin
            n = got.size();
            if (tx_full) wr_full_err++;
            ea = 0;
            if (n >= 4 && n < 132)        ea = (n - 4) / 4;
            else if (n >= 132 && n < 260) ea = (n - 132) / 4;
            if (32'(bus.o_addr) != 32'(ea)) addr_err++;
            if (first_wr_step < 0) first_wr_step = step_cnt;
            got.push_back(bus.o_w_data);
        end
        if (o_done) done_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (!start_hold) i_start = 1'b0;
        tx_full = rand_full ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        step_cnt++;
        sample();
    endtask

    task automatic clear_mon(input bit rnd);
        got.delete();
        done_cnt = 0; wr_full_err = 0; addr_err = 0;
        step_cnt = 0; first_wr_step = -1;
        rand_full = rnd;
    endtask

    task automatic run_dump(input bit rnd, input bit extra, input string tag);
        bit x10, xd;
        int cyc;
        int bad;
        x10 = 0; xd = 0; cyc = 0; bad = 0;
        clear_mon(rnd);
        i_start = 1'b1;
        step();
        while (done_cnt == 0 && cyc < 6000) begin
            if (extra && !x10 && got.size() == 10) begin
                i_start = 1'b1;
                x10 = 1;
            end
            if (extra && !xd && got.size() == EXP_N) begin
                i_start = 1'b1;
                start_hold = 1'b1;
                xd = 1;
            end
            step();
            cyc++;
        end
        start_hold = 1'b0;
        chk({tag, "_done_seen"}, 32'(done_cnt > 0), 32'd1);
        rand_full = 1'b0;
        repeat (20) step();
        i_start = 1'b0;
        chk({tag, "_byte_count"}, 32'(got.size()), 32'(EXP_N));
        chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        chk({tag, "_busy_after"}, 32'(o_busy), 32'd0);
        chk({tag, "_wr_while_full"}, 32'(wr_full_err), 32'd0);
        chk({tag, "_addr_errors"}, 32'(addr_err), 32'd0);
        for (int i = 0; i < got.size() && i < EXP_N; i++)
            if (got[i] !== exp_byte(i)) bad++;
        chk({tag, "_stream_mismatches"}, 32'(bad), 32'd0);
    endtask

    initial begin
        vec_t vecs[14];
        vecs = '{
            '{0, 8'h04}, '{1, 8'h00}, '{2, 8'h00}, '{3, 8'h00},
            '{4, 8'h00}, '{5, 8'h00}, '{6, 8'h00}, '{7, 8'h00},
            '{8, 8'h01}, '{132, 8'h00}, '{133, 8'h00}, '{134, 8'hA5},
            '{135, 8'hA5}, '{259, 8'hA5}
        };
        start_hold = 1'b0;
        clear_mon(1'b0);
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(o_busy), 32'd0);
        chk("reset_done", 32'(o_done), 32'd0);
        chk("reset_wr", 32'(bus.o_wr_uart), 32'd0);
        chk("reset_addr", 32'(bus.o_addr), 32'd0);
        chk("reset_wdata", 32'(bus.o_w_data), 32'd0);
        i_reset = 1'b1;
        repeat (2) step();

        run_dump(1'b0, 1'b0, "plain");
        chk("first_wr_latency", 32'(first_wr_step), 32'd3);
        foreach (vecs[i]) begin
            if (vecs[i].idx < got.size())
                chk($sformatf("byte_%0d", vecs[i].idx), 32'(got[vecs[i].idx]), 32'(vecs[i].exp));
            else
                chk($sformatf("byte_%0d_missing", vecs[i].idx), 32'(got.size()), 32'(vecs[i].idx + 1));
        end
`ifdef DEBUG_DUMP_CHECKSUM_EN
        if (got.size() == 261) chk("checksum_byte", 32'(got[260]), 32'(exp_byte(260)));
        else chk("checksum_present", 32'(got.size()), 32'd261);
`endif

        run_dump(1'b1, 1'b0, "backpressure");

        run_dump(1'b0, 1'b1, "extra_start");

        clear_mon(1'b0);
        i_start = 1'b1;
        step();
        for (int c = 0; c < 2000 && got.size() < 50; c++) step();
        chk("abort_reached_50", 32'(got.size()), 32'd50);
        i_reset = 1'b0;
        #1;
        chk("abort_busy", 32'(o_busy), 32'd0);
        chk("abort_done", 32'(o_done), 32'd0);
        chk("abort_wr", 32'(bus.o_wr_uart), 32'd0);
        chk("abort_addr", 32'(bus.o_addr), 32'd0);
        chk("abort_wdata", 32'(bus.o_w_data), 32'd0);
        repeat (2) step();
        @(negedge clk);
        i_reset = 1'b1;
        repeat (10) step();
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        chk("abort_bytes_frozen", 32'(got.size()), 32'd50);

        run_dump(1'b0, 1'b0, "restart");
        if (got.size() >= 4)
            chk("restart_pc_word", {got[3], got[2], got[1], got[0]}, 32'h0000_0004);
        else
            chk("restart_pc_word_missing", 32'(got.size()), 32'd4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/debug_dump_sequencer.md
Name: debug_dump_sequencer

Overview:
- Sequences the post-halt state dump from the pipeline debug port into the UART TX FIFO.
- On start, sends the following to the host as little-endian bytes:
  - PC: 1 word
  - register file: N_REGS words
  - data memory: N_MEM words
- Drives the shared debug address bus. Handshakes with the FIFO via full/write-strobe.
- Sits between the pipeline debug outputs and the uart instance inside debugger_top; default dump is 4+128+128 = 260 bytes.

Parameters:
- DATA_SZ, 32, width of PC / register / memory words (multiple of 8)
- ADDR_W, 5, width of the debug address bus
- N_REGS, 32, number of register words dumped
- N_MEM, 32, number of memory words dumped
- BYTE_W, 8, UART byte width

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous reset, active-low
- i_start  in  1  one-cycle pulse; begin dump (ignored while busy)
- i_pc  in  DATA_SZ  current PC from pipeline
- i_register_data  in  DATA_SZ  register read data at o_addr
- i_memory_data  in  DATA_SZ  data-memory read data at o_addr
- i_tx_full  in  1  UART TX FIFO full
- o_addr  out  ADDR_W  debug read address to pipeline
- o_w_data  out  BYTE_W  byte to TX FIFO
- o_wr_uart  out  1  TX FIFO write strobe, one cycle per byte
- o_busy  out  1  dump in progress
- o_done  out  1  one-cycle pulse after the last byte is written

Behaviour:
- Reset (i_reset=0, async): state=IDLE.
  - o_addr=0, o_w_data=0, o_wr_uart=0, o_busy=0, o_done=0.
  - Word, byte and source counters cleared.
- States:
  - IDLE: wait for i_start.
  - SETUP: drive o_addr; one-cycle read latency.
  - LATCH: capture the selected source word into the shift register.
  - SEND: emit bytes.
  - ADVANCE: pick the next word or source.
  - DONE: pulse o_done.
- IDLE -> SETUP on i_start=1. Source=PC, addr=0, o_busy=1 from the next cycle.
- SETUP -> LATCH unconditionally.
- LATCH: captures the word, byte index=0.
  - Source PC uses i_pc.
  - Source REG uses i_register_data.
  - Source MEM uses i_memory_data.
- SEND, each cycle:
  - If i_tx_full=0: o_wr_uart=1, o_w_data=word[8*idx +: 8], idx++.
  - If i_tx_full=1: o_wr_uart=0 and idx holds. No byte is lost or duplicated.
- SEND -> ADVANCE after byte DATA_SZ/8-1 is written.
- ADVANCE:
  - PC -> REG with addr=0.
  - REG with addr<N_REGS-1: addr+1.
  - REG last -> MEM with addr=0.
  - MEM with addr<N_MEM-1: addr+1.
  - MEM last -> DONE.
  - Otherwise -> SETUP.
- DONE: o_done=1 for one cycle, o_busy=0, o_addr=0; -> IDLE.
- Byte order: LSB first within each word.
- Latency: first o_wr_uart is 3 cycles after i_start (with i_tx_full=0).
- Best-case total = 4 + (1+N_REGS+N_MEM)×(3 + DATA_SZ/8) cycles.
- o_addr is stable through SETUP, LATCH and SEND of each word. It is don't-care-but-0 for PC.
- i_start while o_busy=1: ignored. i_start in the DONE cycle: ignored.
- o_wr_uart is never asserted in a cycle where i_tx_full=1.
- Reset mid-dump: abort immediately to IDLE. No o_done pulse. The next i_start restarts from PC.
- Counters are sized with $clog2. Address wrap is impossible by construction (N ≤ 2^ADDR_W, checked at elaboration).

Optional Feature:
- Macro: DEBUG_DUMP_CHECKSUM_EN
- Defined:
  - A running XOR of all emitted bytes is cleared on i_start.
  - After the last MEM byte, state CHKSUM emits one extra byte = XOR (same full handshake) before DONE.
  - Default dump = 261 bytes.
- Undefined: no CHKSUM state, no accumulator; 260 bytes.

Decomposition:
- Shared package debug_pkg:
  - state enum (IDLE, SETUP, LATCH, SEND, ADVANCE, CHKSUM, DONE)
  - source enum (SRC_PC, SRC_REG, SRC_MEM)
  - localparam BYTES_PER_WORD = DATA_SZ/BYTE_W
- One natural sub-module, word_serializer: load word, shift out bytes under the tx_full handshake, and assert last_byte. The FSM/source sequencing stays in the top.

Test Plan:
- Reset then i_start with i_pc=0x0000_0004, reg[k]=k, mem[k]=0xA5A5_0000+k, i_tx_full=0:
  - exactly 260 write strobes;
  - bytes 0..3 = 04 00 00 00;
  - bytes 4..7 = 00 00 00 00 (reg0);
  - byte 132 = 00, byte 133 = 00, byte 134 = A5, byte 135 = A5 (mem0);
  - final byte = A5;
  - o_done pulses once.
- i_tx_full toggled pseudo-randomly (50%) during the dump:
  - same 260-byte sequence as the first scenario;
  - no o_wr_uart while full.
- o_addr check: during reg word k, o_addr=k. Reg word 31 is followed by mem word 0 with o_addr=0.
- Reset asserted after byte 50:
  - all outputs 0 within the same cycle;
  - no o_done;
  - a new i_start replays from the PC byte 04.
- Extra i_start pulses at byte 10 and in the DONE cycle: byte count is still 260 and o_done pulses once.
- With DEBUG_DUMP_CHECKSUM_EN: 261 bytes, and the last byte equals the XOR of the preceding 260. Without it: 260 bytes.
